checkout_scan_controller: RTL and testbench

Sequencing controller wrapped around the existing combinational electronicDetectorDevice (U, P, C, M -> discount, stolen) for the checkout-station board design. It accepts one scan request at a time and registers the item code. It evaluates the code through a single detector instance, keeps saturating per-session item and discount counts, and latches a theft alarm until an operator clears it. It sits between the debounced KEY/SW front end and the LEDR/HEX display logic in DE1_SoC.

---
 rtl/checkout_pkg.sv | 11 +
 rtl/electronicDetectorDevice.sv | 12 +
 rtl/checkout_scan_controller.sv | 85 ++++++++
 tb/tb_checkout_scan_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/checkout_pkg.sv
// checkout_pkg: shared types for the checkout scan controller
package checkout_pkg;
    typedef enum logic [1:0] {IDLE, EVAL, WAIT_REL, ALARM} state_t;
    localparam int CNT_W_DEF = 4;
    typedef struct packed {
        logic u;
        logic p;
        logic c;
        logic m;
    } code_t;
endpackage

// File: rtl/electronicDetectorDevice.sv
// electronicDetectorDevice: combinational discount/theft decode of an item code
module electronicDetectorDevice (
    input  logic U,
    input  logic P,
    input  logic C,
    input  logic M,
    output logic discount,
    output logic stolen
);
    assign discount = P | (U & C);
    assign stolen   = ~M & ~P & (U | ~C);
endmodule

// File: rtl/checkout_scan_controller.sv
// checkout_scan_controller: one-at-a-time scan sequencing, session counters and theft alarm
module checkout_scan_controller
    import checkout_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_valid,
    input  logic [2:0]       upc,
    input  logic             marked,
    input  logic             clear_alarm,
    input  logic             clear_counts,
    output logic             busy,
    output logic             result_valid,
    output logic             last_discount,
    output logic             last_stolen,
    output logic             alarm,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] discount_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_next;
    code_t  code;
    logic   discount, stolen;

    electronicDetectorDevice u_det (
        .U(code.u),
        .P(code.p),
        .C(code.c),
        .M(code.m),
        .discount(discount),
        .stolen(stolen)
    );

    assign busy  = state != IDLE;
    assign alarm = state == ALARM;

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    // next-state decode; a held scan parks in WAIT_REL so it is counted once
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = scan_valid ? EVAL : IDLE;
            EVAL:     state_next = stolen ? ALARM : WAIT_REL;
            WAIT_REL: state_next = scan_valid ? WAIT_REL : IDLE;
            ALARM:    state_next = clear_alarm ? WAIT_REL : ALARM;
            default:  state_next = IDLE;
        endcase
    end

    // code capture, result publication and saturating session counters
    always_ff @(posedge clk) begin
        if (reset) begin
            code           <= '0;
            result_valid   <= 1'b0;
            last_discount  <= 1'b0;
            last_stolen    <= 1'b0;
            item_count     <= '0;
            discount_count <= '0;
        end else begin
            result_valid <= state == EVAL;
            if (state == IDLE && scan_valid)
                code <= {upc, marked};
            if (state == EVAL) begin
                last_discount <= discount;
                last_stolen   <= stolen;
            end
            if (clear_counts) begin
                item_count     <= '0;
                discount_count <= '0;
            end else if (state == EVAL) begin
                if (item_count != CNT_MAX)
                    item_count <= item_count + 1'b1;
                if (discount && discount_count != CNT_MAX)
                    discount_count <= discount_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_checkout_scan_controller.sv
// tb_checkout_scan_controller: randomized and directed checks against a behavioural model
module tb_checkout_scan_controller;
    localparam int CNT_W = 4;
    localparam int SAT = (1 << CNT_W) - 1;

    logic clk = 0, reset = 1, scan_valid = 0, marked = 0, clear_alarm = 0, clear_counts = 0;
    logic [2:0] upc = 0;
    logic busy, result_valid, last_discount, last_stolen, alarm;
    logic [CNT_W-1:0] item_count, discount_count;

    int compared = 0, mismatched = 0;

    logic [15:0] gold_d = 16'b1111_1100_1111_0000;
    logic [15:0] gold_s = 16'b0000_0101_0000_0001;

    logic m_pend = 0, m_wait = 0, m_alrm = 0, m_rv = 0, m_ld = 0, m_ls = 0;
    logic [3:0] m_code = 0;
    int m_ic = 0, m_dc = 0;

    checkout_scan_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .upc(upc), .marked(marked),
        .clear_alarm(clear_alarm), .clear_counts(clear_counts), .busy(busy),
        .result_valid(result_valid), .last_discount(last_discount), .last_stolen(last_stolen),
        .alarm(alarm), .item_count(item_count), .discount_count(discount_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic was_pend;
        if (reset) begin
            {m_pend, m_wait, m_alrm, m_rv, m_ld, m_ls} = '0;
            m_code = 0;
            m_ic = 0;
            m_dc = 0;
        end else begin
            was_pend = m_pend;
            m_rv = was_pend;
            if (was_pend) begin
                m_ld = gold_d[m_code];
                m_ls = gold_s[m_code];
                m_ic = (m_ic < SAT) ? m_ic + 1 : m_ic;
                m_dc = (m_ld && m_dc < SAT) ? m_dc + 1 : m_dc;
                m_pend = 0;
                m_alrm = m_ls;
                m_wait = !m_ls;
            end else if (m_alrm) begin
                m_alrm = !clear_alarm;
                m_wait = clear_alarm;
            end else if (m_wait) begin
                m_wait = scan_valid;
            end else if (scan_valid) begin
                m_pend = 1;
                m_code = {upc, marked};
            end
            if (clear_counts) begin
                m_ic = 0;
                m_dc = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [3:0] cd, input logic ca, input logic cc);
        reset = r;
        scan_valid = s;
        {upc, marked} = cd;
        clear_alarm = ca;
        clear_counts = cc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("busy", busy, m_pend | m_wait | m_alrm);
        chk("alarm", alarm, m_alrm);
        chk("result_valid", result_valid, m_rv);
        chk("last_discount", last_discount, m_ld);
        chk("last_stolen", last_stolen, m_ls);
        chk("item_count", item_count, m_ic);
        chk("discount_count", discount_count, m_dc);
    endtask

    task automatic scan_item(input logic [3:0] cd, input logic cc_on_eval);
        int n;
        step(0, 1, cd, 0, 0);
        step(0, 0, 4'($urandom), 0, cc_on_eval);
        n = 0;
        while ((m_pend | m_wait | m_alrm) && n < 10) begin
            step(0, 0, 4'($urandom), m_alrm, 0);
            n++;
        end
        if (n >= 10) chk("scan_timeout", n, 0);
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 1, 4'hf, 1, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", item_count, 0);
        // reset lands on the EVAL edge of a stolen code
        step(0, 1, 4'b0000, 0, 0);
        step(1, 1, 4'b0000, 0, 0);
        chk("rst_eval_alarm", alarm, 0);
        chk("rst_eval_rv", result_valid, 0);
        chk("rst_eval_count", item_count, 0);
        step(0, 0, 0, 0, 0);
        // discount code held five cycles
        for (int i = 0; i < 5; i++) step(0, 1, 4'b0100, 0, 0);
        chk("held_count", item_count, 1);
        chk("held_disc", discount_count, 1);
        step(0, 0, 0, 0, 0);
        chk("held_release_busy", busy, 0);
        // stolen code, ignored scans while alarmed, then clear
        step(0, 1, 4'b0000, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("stolen_alarm", alarm, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'b0100, 0, 0);
            step(0, 0, 4'b0100, 0, 0);
        end
        chk("alarm_ignores_scan", item_count, 2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("alarm_cleared", alarm, 0);
        chk("alarm_cleared_idle", busy, 0);
        // saturation
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) scan_item(4'b0011, 0);
        chk("sat_items", item_count, SAT);
        chk("sat_disc", discount_count, 0);
        // clear on the EVAL edge of the third scan
        step(0, 0, 0, 0, 1);
        scan_item(4'b1010, 0);
        scan_item(4'b0110, 0);
        scan_item(4'b0100, 1);
        chk("clr_eval_items", item_count, 0);
        // every code in turn
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            scan_item(4'(i), 0);
            chk("all_codes_disc", last_discount, gold_d[i]);
            chk("all_codes_stolen", last_stolen, gold_s[i]);
        end
        chk("all_codes_items", item_count, SAT);
        // random traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(63) == 0, $urandom_range(2) != 0, 4'($urandom),
                 $urandom_range(3) == 0, $urandom_range(15) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
